// File: rtl/dma_pkg.sv
// Shared definitions for the DMA AXI read path: arbiter states,
// AXI burst/size codes and the AXI ID width.
package dma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_1B   = 3'd0;
    localparam logic [2:0] SIZE_2B   = 3'd1;
    localparam logic [2:0] SIZE_4B   = 3'd2;
    localparam logic [2:0] SIZE_8B   = 3'd3;
    localparam logic [2:0] SIZE_16B  = 3'd4;
    localparam logic [2:0] SIZE_32B  = 3'd5;
    localparam logic [2:0] SIZE_64B  = 3'd6;
    localparam logic [2:0] SIZE_128B = 3'd7;

    localparam int AXI_ID_W = 4;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set request bit at or
// after ptr, wrapping at NUM_CH.
module dma_rr_pick
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  win,
    output logic              found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/dma_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read master among NUM_CH requesters.
// Optional watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_axi_rd_arb
    import dma_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_CH-1:0]     ch_arvalid,
    input  logic [NUM_CH*ADDR_W-1:0] ch_araddr,
    input  logic [NUM_CH*4-1:0]   ch_arlen,
    input  logic [NUM_CH*3-1:0]   ch_arsize,
    input  logic [NUM_CH*2-1:0]   ch_arburst,
    output logic [NUM_CH-1:0]     ch_arready,
    output logic [NUM_CH-1:0]     ch_rvalid,
    input  logic [NUM_CH-1:0]     ch_rready,
    output logic [DATA_W-1:0]     ch_rdata,
    output logic [1:0]            ch_rresp,
    output logic                  ch_rlast,
    output logic [AXI_ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [AXI_ID_W-1:0]   RID,
    input  logic [DATA_W-1:0]     RDATA_I,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic                  rid_err,
    output logic                  busy,
    output logic                  tmo_err
);

    localparam int IDX_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 2) begin : g_param_chk
        $error("dma_axi_rd_arb: parameter out of range");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] cur, rr_ptr, win, cur_inc;
    logic             found, ar_hs, r_hs, tmo_hit;

    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [3:0]        len_a   [NUM_CH];
    logic [2:0]        size_a  [NUM_CH];
    logic [1:0]        burst_a [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign addr_a[i]  = ch_araddr[i*ADDR_W +: ADDR_W];
        assign len_a[i]   = ch_arlen[i*4 +: 4];
        assign size_a[i]  = ch_arsize[i*3 +: 3];
        assign burst_a[i] = ch_arburst[i*2 +: 2];
    end

    dma_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (ch_arvalid),
        .ptr   (rr_ptr),
        .win   (win),
        .found (found)
    );

    assign cur_inc  = (cur == IDX_W'(NUM_CH - 1)) ? '0 : cur + 1'b1;
    assign ar_hs    = (state == ARB_ADDR) && ARVALID && ARREADY;
    assign r_hs     = (state == ARB_DATA) && RVALID && ch_rready[cur];
    assign busy     = (state != ARB_IDLE);
    assign ARID     = AXI_ID_W'(cur);
    assign ch_rdata = RDATA_I;
    assign ch_rresp = RRESP;
    assign ch_rlast = RLAST;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ch_arready = '0;
        ch_rvalid  = '0;
        RREADY     = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (found) state_nxt = ARB_ADDR;
            end
            ARB_ADDR: begin
                if (ar_hs) begin
                    ch_arready[cur] = 1'b1;
                    state_nxt       = ARB_DATA;
                end
            end
            ARB_DATA: begin
                ch_rvalid[cur] = RVALID;
                RREADY         = ch_rready[cur];
                if (r_hs && RLAST) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (tmo_hit) state_nxt = ARB_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur     <= '0;
            rr_ptr  <= '0;
            ARVALID <= 1'b0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
            ARBURST <= '0;
            rid_err <= 1'b0;
        end else begin
            if (state == ARB_IDLE && found) begin
                cur     <= win;
                ARVALID <= 1'b1;
                ARADDR  <= addr_a[win];
                ARLEN   <= len_a[win];
                ARSIZE  <= size_a[win];
                ARBURST <= burst_a[win];
            end
            if (ar_hs || tmo_hit) begin
                ARVALID <= 1'b0;
                rr_ptr  <= cur_inc;
            end
            // Mismatched RID is flagged but the beat still goes to cur.
            if (state == ARB_DATA && RVALID && RID != ARID) rid_err <= 1'b1;
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = busy && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state_nxt != state || r_hs) tmo_cnt <= '0;
            else if (busy)                  tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) tmo_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_axi_rd_arb.sv
// Randomized bench for dma_axi_rd_arb against a burst-level
// round-robin reference model.
module tb_dma_axi_rd_arb;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  ch_arvalid;
    logic [N*AW-1:0] ch_araddr;
    logic [N*4-1:0] ch_arlen;
    logic [N*3-1:0] ch_arsize;
    logic [N*2-1:0] ch_arburst;
    logic [N-1:0]  ch_arready;
    logic [N-1:0]  ch_rvalid;
    logic [N-1:0]  ch_rready;
    logic [DW-1:0] ch_rdata;
    logic [1:0]    ch_rresp;
    logic          ch_rlast;
    logic [3:0]    ARID;
    logic [AW-1:0] ARADDR;
    logic [3:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA_I;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          rid_err;
    logic          busy;
    logic          tmo_err;

    dma_axi_rd_arb #(
        .NUM_CH (N),
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(1024)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ch_arvalid (ch_arvalid),
        .ch_araddr  (ch_araddr),
        .ch_arlen   (ch_arlen),
        .ch_arsize  (ch_arsize),
        .ch_arburst (ch_arburst),
        .ch_arready (ch_arready),
        .ch_rvalid  (ch_rvalid),
        .ch_rready  (ch_rready),
        .ch_rdata   (ch_rdata),
        .ch_rresp   (ch_rresp),
        .ch_rlast   (ch_rlast),
        .ARID       (ARID),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARBURST    (ARBURST),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RID        (RID),
        .RDATA_I    (RDATA_I),
        .RRESP      (RRESP),
        .RLAST      (RLAST),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .rid_err    (rid_err),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester-side view of pending bursts
    bit          pend    [N];
    logic [31:0] f_addr  [N];
    logic [3:0]  f_len   [N];
    logic [2:0]  f_size  [N];
    logic [1:0]  f_burst [N];

    // Burst-level model: who owns the bus and how far along it is
    int          owner, last_grant, beats_left, beats_seen;
    bit          ar_done, exp_rid_err;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    int          grants[$];

    int          p_req, p_arready, p_rvalid, p_rready, fix_len;
    logic [N-1:0] req_mask;
    logic [31:0] fix_addr;
    bit          fix_addr_en, scramble, rid_force, drop_en;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic model_reset();
        owner       = -1;
        last_grant  = N - 1;
        beats_left  = 0;
        beats_seen  = 0;
        ar_done     = 1'b0;
        exp_rid_err = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    task automatic clear_inputs();
        ch_arvalid = '0;
        ch_araddr  = '0;
        ch_arlen   = '0;
        ch_arsize  = '0;
        ch_arburst = '0;
        ch_rready  = '0;
        ARREADY    = 1'b0;
        RID        = '0;
        RDATA_I    = '0;
        RRESP      = '0;
        RLAST      = 1'b0;
        RVALID     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn     = 1'b0;
        ch_arvalid = '1;
        ch_rready  = '1;
        ARREADY    = 1'b1;
        RVALID     = 1'b1;
        RLAST      = 1'b1;
        RID        = 4'd9;
        @(negedge clk);
        chk("rst_ar", {ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST}, '0);
        chk("rst_flags", {busy, rid_err, tmo_err}, '0);
        chk("rst_ch", {ch_arready, ch_rvalid, RREADY}, '0);
        clear_inputs();
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && req_mask[i] && roll(p_req)) begin
                pend[i]    = 1'b1;
                f_addr[i]  = fix_addr_en ? fix_addr : $urandom;
                f_len[i]   = (fix_len >= 0) ? 4'(fix_len) : 4'($urandom_range(7));
                f_size[i]  = 3'($urandom_range(7));
                f_burst[i] = 2'($urandom_range(3));
            end
        end
        // A granted request may change its fields before ch_arready
        if (owner >= 0 && !ar_done && scramble) begin
            f_addr[owner]  = $urandom;
            f_len[owner]   = 4'($urandom_range(15));
            f_size[owner]  = 3'($urandom_range(7));
            f_burst[owner] = 2'($urandom_range(3));
        end
        for (int i = 0; i < N; i++) begin
            ch_arvalid[i] = pend[i] &&
                !(drop_en && owner == i && !ar_done && roll(50));
            ch_araddr[i*AW +: AW] = f_addr[i];
            ch_arlen[i*4 +: 4]    = f_len[i];
            ch_arsize[i*3 +: 3]   = f_size[i];
            ch_arburst[i*2 +: 2]  = f_burst[i];
            ch_rready[i]          = roll(p_rready);
        end
        ARREADY = roll(p_arready);
        RVALID  = roll(p_rvalid);
        RDATA_I = {$urandom, $urandom, $urandom, $urandom};
        RRESP   = 2'($urandom_range(3));
        if (rid_force)       RID = 4'd3;
        else if (owner >= 0) RID = 4'(owner);
        else                 RID = 4'($urandom_range(15));
        if (owner >= 0 && ar_done) RLAST = (beats_left == 1);
        else                       RLAST = 1'($urandom_range(1));
    endtask

    task automatic check_update();
        logic [N-1:0] oh;
        oh = '0;
        if (owner >= 0) oh[owner] = 1'b1;
        chk("rid_err", rid_err, exp_rid_err);
        chk("tmo_err", tmo_err, 1'b0);
        chk("rdata", ch_rdata, RDATA_I);
        chk("rresp_last", {ch_rresp, ch_rlast}, {RRESP, RLAST});
        if (owner < 0) begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_ch", {ARVALID, ch_arready, ch_rvalid, RREADY}, '0);
            if (|ch_arvalid) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last_grant + k) % N;
                    if (ch_arvalid[c]) begin
                        owner = c;
                        break;
                    end
                end
                ar_done = 1'b0;
                e_addr  = f_addr[owner];
                e_len   = f_len[owner];
                e_size  = f_size[owner];
                e_burst = f_burst[owner];
            end
        end else if (!ar_done) begin
            chk("addr_busy", {busy, ARVALID}, 2'b11);
            chk("arid", ARID, owner);
            chk("ar_fields", {ARADDR, ARLEN, ARSIZE, ARBURST},
                {e_addr, e_len, e_size, e_burst});
            chk("arready", ch_arready, ARREADY ? oh : '0);
            chk("addr_r", {ch_rvalid, RREADY}, '0);
            if (ARREADY) begin
                ar_done    = 1'b1;
                pend[owner] = 1'b0;
                beats_left = int'(e_len) + 1;
                beats_seen = 0;
                last_grant = owner;
                grants.push_back(owner);
            end
        end else begin
            chk("data_busy", {busy, ARVALID, ch_arready}, {1'b1, 1'b0, 4'b0});
            chk("rvalid", ch_rvalid, RVALID ? oh : '0);
            chk("rready", RREADY, ch_rready[owner]);
            if (RVALID && RID != 4'(owner)) exp_rid_err = 1'b1;
            if (RVALID && ch_rready[owner]) begin
                beats_left--;
                beats_seen++;
                if (beats_left == 0) owner = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_update();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        resetn      = 1'b0;
        clear_inputs();
        model_reset();
        p_req       = 100;
        p_arready   = 100;
        p_rvalid    = 100;
        p_rready    = 100;
        fix_len     = 3;
        req_mask    = '0;
        fix_addr    = 32'h1000;
        fix_addr_en = 1'b1;
        scramble    = 1'b0;
        rid_force   = 1'b0;
        drop_en     = 1'b0;
        do_reset();

        // Single request on channel 0
        req_mask = 4'b0001;
        grants.delete();
        t = 0;
        while (!(grants.size() > 0 && owner < 0) && t < 50) begin
            step();
            if (grants.size() > 0) req_mask = '0;
            t++;
        end
        chk("p1_done", t < 50, 1'b1);
        chk("p1_grant", grants.size() > 0 ? grants[0] : -1, 0);
        chk("p1_beats", beats_seen, 4);
        fix_addr_en = 1'b0;

        // All four requesting continuously, single-beat bursts
        do_reset();
        req_mask = '1;
        fix_len  = 0;
        grants.delete();
        t = 0;
        while (grants.size() < 5 && t < 100) begin
            step();
            t++;
        end
        chk("p2_done", grants.size() >= 5, 1'b1);
        for (int k = 0; k < 5; k++)
            chk("p2_order", grants.size() > k ? grants[k] : -1, k % 4);

        // AR stall while the granted slot's fields change
        do_reset();
        req_mask  = 4'b0010;
        fix_len   = -1;
        p_arready = 0;
        scramble  = 1'b1;
        t = 0;
        while (owner != 1 && t < 10) begin
            step();
            t++;
        end
        req_mask = '0;
        for (int k = 0; k < 5; k++) step();
        chk("p3_hold", {ARVALID, busy}, 2'b11);
        p_arready = 100;
        t = 0;
        while (owner >= 0 && t < 40) begin
            step();
            t++;
        end
        chk("p3_done", t < 40, 1'b1);
        scramble = 1'b0;

        // R backpressure on channel 2
        req_mask = 4'b0100;
        fix_len  = 3;
        p_rready = 0;
        t = 0;
        while (!(owner == 2 && ar_done) && t < 20) begin
            step();
            t++;
        end
        req_mask = '0;
        for (int k = 0; k < 3; k++) step();
        chk("p4_stalled", beats_seen, 0);
        p_rready = 100;
        t = 0;
        while (owner >= 0 && t < 40) begin
            step();
            t++;
        end
        chk("p4_beats", beats_seen, 4);

        // RID mismatch while channel 1 owns the bus
        req_mask  = 4'b0010;
        rid_force = 1'b1;
        fix_len   = 1;
        grants.delete();
        t = 0;
        while (!(grants.size() > 0 && owner < 0) && t < 40) begin
            step();
            if (grants.size() > 0) req_mask = '0;
            t++;
        end
        step();
        chk("p5_rid_err", rid_err, 1'b1);
        rid_force = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("p5_sticky", rid_err, 1'b1);
        do_reset();

        // Random traffic
        req_mask  = '1;
        fix_len   = -1;
        p_req     = 30;
        p_arready = 60;
        p_rvalid  = 60;
        p_rready  = 70;
        scramble  = 1'b1;
        drop_en   = 1'b1;
        grants.delete();
        for (int k = 0; k < 3000; k++) step();
        chk("rand_progress", grants.size() > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
